gcd_driver: RTL

GCD_DRIVER -- requirements
Module: gcd_driver

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_slot_ram.sv | 42 ++++
 rtl/gcd_driver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core driver: FSM state encoding and default sizing.
package gcd_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_AVAIL,
    ISSUE,
    WAIT_RESULT,
    ACK,
    WAIT_CLR,
    DONE
  } gcd_state_t;

endpackage

// File: rtl/gcd_slot_ram.sv
// Operand-pair table ({A,B} per slot) and result table, each with one write port
// and one combinational read port. Only the result table is cleared by reset.
module gcd_slot_ram
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pair_we,
  input  logic [AW-1:0]      pair_waddr,
  input  logic [2*WIDTH-1:0] pair_wdata,
  input  logic [AW-1:0]      pair_raddr,
  output logic [2*WIDTH-1:0] pair_rdata,
  input  logic               res_we,
  input  logic [AW-1:0]      res_waddr,
  input  logic [WIDTH-1:0]   res_wdata,
  input  logic [AW-1:0]      res_raddr,
  output logic [WIDTH-1:0]   res_rdata
);

  logic [2*WIDTH-1:0] pairs   [DEPTH];
  logic [WIDTH-1:0]   results [DEPTH];

  always_ff @(posedge clk) begin
    if (pair_we) pairs[pair_waddr] <= pair_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) results[i] <= '0;
    end else if (res_we) begin
      results[res_waddr] <= res_wdata;
    end
  end

  assign pair_rdata = pairs[pair_raddr];
  assign res_rdata  = results[res_raddr];

endmodule

// File: rtl/gcd_driver.sv
// Sequences stored operand pairs through an external GCD core one at a time,
// collecting each result with a per-transaction watchdog.
module gcd_driver
  import gcd_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1,
  localparam int WW     = $clog2(TIMEOUT) + 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_a,
  input  logic [WIDTH-1:0] load_b,
  output logic             load_ready,
  input  logic             clear,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] operand_A,
  output logic [WIDTH-1:0] operand_B,
  input  logic             input_available,
  output logic             input_ready,
  input  logic             result_rdy,
  input  logic [WIDTH-1:0] result_data,
  output logic             result_taken
);

  gcd_state_t state, state_nx;

  logic [CW-1:0]      count;
  logic [AW-1:0]      idx;
  logic [WW-1:0]      wdog;
  logic [WIDTH-1:0]   hold_a, hold_b;
  logic [2*WIDTH-1:0] pair_rdata;
  logic               pair_we, res_we;
  logic [WIDTH-1:0]   res_wdata;
  logic               active, wdog_hit, last;

  assign active   = (state == WAIT_AVAIL) || (state == ISSUE) || (state == WAIT_RESULT);
  assign wdog_hit = (wdog == WW'(TIMEOUT - 1));
  assign last     = ((CW'(idx) + CW'(1)) >= count);

  assign load_ready   = (state == IDLE) && (count < CW'(DEPTH));
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign input_ready  = (state == ISSUE);
  assign result_taken = (state == ACK);

  // Operands track the selected pair while a transaction is live, then freeze.
  assign operand_A = active ? pair_rdata[2*WIDTH-1:WIDTH] : hold_a;
  assign operand_B = active ? pair_rdata[WIDTH-1:0]       : hold_b;

  gcd_slot_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_slot_ram (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .pair_we    (pair_we),
    .pair_waddr (count[AW-1:0]),
    .pair_wdata ({load_a, load_b}),
    .pair_raddr (idx),
    .pair_rdata (pair_rdata),
    .res_we     (res_we),
    .res_waddr  (idx),
    .res_wdata  (res_wdata),
    .res_raddr  (rd_addr),
    .res_rdata  (rd_data)
  );

  always_comb begin
    state_nx  = state;
    pair_we   = 1'b0;
    res_we    = 1'b0;
    res_wdata = result_data;
    case (state)
      IDLE: begin
        pair_we = load_valid && load_ready && !clear && !sys_rst;
        if (!clear && start) state_nx = (count != '0) ? WAIT_AVAIL : DONE;
      end
      WAIT_AVAIL: if (input_available) state_nx = ISSUE;
      ISSUE:      state_nx = WAIT_RESULT;
      WAIT_RESULT: begin
        if (result_rdy) begin
          res_we   = 1'b1;
          state_nx = ACK;
        end else if (wdog_hit) begin
          res_we    = 1'b1;
          res_wdata = '1;
          state_nx  = DONE;
        end
      end
      ACK:      state_nx = WAIT_CLR;
      WAIT_CLR: if (!result_rdy) state_nx = last ? DONE : WAIT_AVAIL;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      count  <= '0;
      idx    <= '0;
      wdog   <= '0;
      error  <= 1'b0;
      hold_a <= '0;
      hold_b <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && clear) begin
        count <= '0;
        idx   <= '0;
      end else begin
        if (pair_we) count <= count + CW'(1);
        if (state == IDLE && start && count != '0) begin
          idx   <= '0;
          error <= 1'b0;
        end
      end
      if (state == ISSUE) wdog <= '0;
      else if (state == WAIT_RESULT) wdog <= wdog + WW'(1);
      if (state == WAIT_RESULT && !result_rdy && wdog_hit) error <= 1'b1;
      if (state == WAIT_CLR && !result_rdy && !last) idx <= idx + AW'(1);
      if (active) begin
        hold_a <= pair_rdata[2*WIDTH-1:WIDTH];
        hold_b <= pair_rdata[WIDTH-1:0];
      end
    end
  end

endmodule
